pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage IF/ID/EX/MA/WB pipeline. Detects RAW hazards from the
//  EX/MA/WB destination registers, squashes wrong-path fetches on taken branches, and freezes
//  the pipe during multi-cycle memory access. On the MA "over" signal it drains the pipeline
//  and halts. It replaces the ad-hoc per-stage delay logic with one stall/flush source.
// PARAMETERS
//  FORWARD       0   1: EX/MA bypass exists, so only load-use in EX stalls; 0: any EX/MA/WB match stalls
//  DRAIN_CYCLES  3   cycles fetch stays disabled after over before halted asserts (1..15)
//  CNT_W         16  width of the stall performance counter
// PORTS
//  clk          in   1      pipeline clock, all state on posedge
//  reset        in   1      asynchronous, active-low reset
//  id_rs        in   5      ID source register A
//  id_rt        in   5      ID source register B
//  id_rs_used   in   1      ID instruction reads id_rs
//  id_rt_used   in   1      ID instruction reads id_rt
//  ex_dest      in   5      EX destination register; 0 = no write
//  ex_load      in   1      EX instruction is a load
//  ma_dest      in   5      MA destination register; 0 = no write
//  wb_dest      in   5      WB destination register; 0 = no write
//  br_taken     in   1      EX resolved a taken branch or jump this cycle
//  mem_busy     in   1      MA access not complete; MA result not valid
//  over         in   1      end-of-program indication from MA (level)
//  delay        out  1      hold PC and IF/ID register
//  bubble       out  1      load NOP into ID/EX instead of the ID result
//  flush        out  1      squash IF/ID contents (wrong path)
//  freeze       out  1      hold ID/EX, EX/MA and MA/WB registers
//  fetch_en     out  1      IF may issue a fetch
//  halted       out  1      pipeline drained; sticky until reset
//  stall_count  out  CNT_W  number of cycles with delay=1; saturates at all-ones
// BEHAVIOUR
//  Reset (reset=0, async): state=RUN; fetch_en=1; halted=0; stall_count=0. delay, bubble,
//   flush and freeze are forced to 0 while reset=0.
//  delay, bubble, flush and freeze are combinational from state and inputs (same cycle).
//   fetch_en, halted and stall_count are registered.
//  RAW hit: (id_rs_used & id_rs!=0 & id_rs==D) | (id_rt_used & id_rt!=0 & id_rt==D).
//   FORWARD=0: D is ex_dest, ma_dest or wb_dest. FORWARD=1: D=ex_dest, and only when ex_load=1.
//  RUN, priority high->low:
//   mem_busy: freeze=1, delay=1, bubble=0, flush=0. No state change, except a latched over.
//   br_taken: flush=1, bubble=1, delay=0. The branch overrides any RAW hit in the same cycle.
//   RAW hit: delay=1, bubble=1, repeated every cycle until the hit clears.
//   otherwise all four outputs are 0.
//  over: sampled in RUN when mem_busy=0. Next state DRAIN, fetch_en<=0, cnt<=DRAIN_CYCLES-1.
//   If over rises while mem_busy=1, a sticky over_pend is set and DRAIN is entered in the
//   first cycle with mem_busy=0.
//  DRAIN: fetch_en=0 and flush=1, so the IF/ID contents are squashed. Hazard and freeze rules
//   still apply to the instructions in flight. cnt decrements only when freeze=0.
//   At cnt==0 and freeze=0: next state HALT.
//  HALT: halted=1, fetch_en=0, freeze=1, delay=1. Inputs are ignored until reset.
//  stall_count increments on every clk edge where delay=1, including in HALT, and holds at
//   2^CNT_W-1.
//  br_taken in DRAIN or HALT is ignored.
//  Reset mid-operation returns to RUN immediately. over_pend and cnt are cleared.
//  Latency: a hazard stall asserts in the same cycle as the hit. Halt asserts DRAIN_CYCLES+1
//   cycles after over is accepted, plus any freeze cycles.
// STRUCTURE
//  Shared package pipe_pkg: state encoding (RUN=2'd0, DRAIN=2'd1, HALT=2'd2), REG_ZERO=5'd0,
//   REG_W=5.
//  Sub-module raw_cmp (src, used, dest -> hit) is instantiated once per source/destination
//   pair. The FSM, drain counter and perf counter sit in the top level.
// TESTING
//  1. FORWARD=0, id_rs=3 used, ma_dest=3 for 2 cycles, then 0 -> delay=bubble=1 for exactly
//     2 cycles; stall_count=2.
//  2. FORWARD=1, ex_load=1, ex_dest=7, id_rt=7 used -> 1-cycle delay+bubble. Same with
//     ex_load=0 -> no stall.
//  3. br_taken=1 and RAW hit in the same cycle -> flush=1, bubble=1, delay=0.
//     id_rs=0 vs ex_dest=0 -> never stalls.
//  4. mem_busy=1 for 4 cycles during a RAW hit -> freeze=delay=1, bubble=0 all 4 cycles;
//     afterwards the RAW stall resumes.
//  5. over=1 with mem_busy=0, DRAIN_CYCLES=3 -> fetch_en=0 next cycle; halted=1 4 cycles
//     after over; halted stays 1 with br_taken toggling.
//  6. over while mem_busy=1 (2 cycles), then reset=0 mid-DRAIN -> DRAIN entered after
//     mem_busy drops; on reset, fetch_en=1, halted=0, stall_count=0 immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the pipeline hazard sequencer:
//                register-file geometry and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Register-file address width and the hard-wired zero register
  localparam int              REG_W    = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t RUN   = 2'd0;
  localparam state_t DRAIN = 2'd1;
  localparam state_t HALT  = 2'd2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/raw_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : raw_cmp
//  Description : Read-after-write comparator for one source/destination pair.
//                Register zero never produces a hazard.
//  Revision    : 1.0 - initial release
// ============================================================================
module raw_cmp
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic [REG_W-1:0] dest,
  output logic             hit
);

  // Hit when the ID instruction really reads a non-zero register being written
  assign hit = used && (src != REG_ZERO) && (src == dest);

endmodule : raw_cmp
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                RAW interlock, branch squash, memory freeze, drain-and-halt,
//                and a saturating stall performance counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FORWARD      = 0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ma_dest,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             over,
  output logic             delay,
  output logic             bubble,
  output logic             flush,
  output logic             freeze,
  output logic             fetch_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int               DCNT_W     = 4;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  logic              w_raw_hit;
  logic              w_delay, w_bubble, w_flush, w_freeze;

  state_t            state_q, state_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic              over_pend_q, over_pend_d;
  logic              fetch_en_q, fetch_en_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  // With bypassing only a load still in EX forces an interlock
  generate
    if (FORWARD != 0) begin : g_fwd
      logic w_rs_hit, w_rt_hit;
      logic w_unused_dest;

      raw_cmp u_rs_ex (.src(id_rs), .used(id_rs_used), .dest(ex_dest), .hit(w_rs_hit));
      raw_cmp u_rt_ex (.src(id_rt), .used(id_rt_used), .dest(ex_dest), .hit(w_rt_hit));

      assign w_raw_hit     = ex_load && (w_rs_hit || w_rt_hit);
      assign w_unused_dest = ^{ma_dest, wb_dest};
    end else begin : g_nofwd
      logic [2:0] w_rs_hit, w_rt_hit;
      logic       w_unused_load;

      raw_cmp u_rs_ex (.src(id_rs), .used(id_rs_used), .dest(ex_dest), .hit(w_rs_hit[0]));
      raw_cmp u_rs_ma (.src(id_rs), .used(id_rs_used), .dest(ma_dest), .hit(w_rs_hit[1]));
      raw_cmp u_rs_wb (.src(id_rs), .used(id_rs_used), .dest(wb_dest), .hit(w_rs_hit[2]));
      raw_cmp u_rt_ex (.src(id_rt), .used(id_rt_used), .dest(ex_dest), .hit(w_rt_hit[0]));
      raw_cmp u_rt_ma (.src(id_rt), .used(id_rt_used), .dest(ma_dest), .hit(w_rt_hit[1]));
      raw_cmp u_rt_wb (.src(id_rt), .used(id_rt_used), .dest(wb_dest), .hit(w_rt_hit[2]));

      assign w_raw_hit     = |{w_rs_hit, w_rt_hit};
      assign w_unused_load = ex_load;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Drain counter, pending-over flag, fetch/halt flags and stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      over_pend_q   <= 1'b0;
      fetch_en_q    <= 1'b1;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      over_pend_q   <= over_pend_d;
      fetch_en_q    <= fetch_en_d;
      halted_q      <= halted_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next-state: accept over when MA is idle, count the drain down while unfrozen
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    over_pend_d   = over_pend_q;
    fetch_en_d    = fetch_en_q;
    halted_d      = halted_q;
    stall_count_d = stall_count_q;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          if (over) over_pend_d = 1'b1;
        end else if (over || over_pend_q) begin
          state_d     = DRAIN;
          fetch_en_d  = 1'b0;
          cnt_d       = DRAIN_LOAD;
          over_pend_d = 1'b0;
        end
      end
      DRAIN: begin
        if (!w_freeze) begin
          if (cnt_q == '0) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      HALT: begin
        fetch_en_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (w_delay && (stall_count_q != CNT_MAX))
      stall_count_d = stall_count_q + 1'b1;
  end

  // Outputs: memory freeze beats branch squash beats RAW interlock
  always_comb begin
    w_delay  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    w_freeze = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          w_freeze = 1'b1;
          w_delay  = 1'b1;
        end else if (br_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_raw_hit) begin
          w_delay  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      DRAIN: begin
        // Fetch is off, so whatever sits in IF/ID is never valid
        w_flush = 1'b1;
        if (mem_busy) begin
          w_freeze = 1'b1;
          w_delay  = 1'b1;
        end else if (w_raw_hit) begin
          w_delay  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      HALT: begin
        w_freeze = 1'b1;
        w_delay  = 1'b1;
      end
      default: ;
    endcase
  end

  // Pipeline controls are held inactive throughout reset
  assign delay       = reset & w_delay;
  assign bubble      = reset & w_bubble;
  assign flush       = reset & w_flush;
  assign freeze      = reset & w_freeze;
  assign fetch_en    = fetch_en_q;
  assign halted      = halted_q;
  assign stall_count = stall_count_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire
